// File: rtl/memory_bus_pkg.sv
// Shared types and defaults for the scratch-memory bus master and the memory it drives.
// Holds the sequencer state encoding, default bus geometry and strobe length, and a
// helper that sizes the strobe down-counter.
package memory_bus_pkg;

    localparam int DEF_DWIDTH     = 8;
    localparam int DEF_AWIDTH     = 5;
    localparam int DEF_STROBE_CYC = 2;

    // V* states exist only when read-back verification is compiled in.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        VSETUP,
        VSTROBE,
        VHOLD
    } bus_state_t;

    // Counter runs from cyc-1 down to 0, so it never needs more than clog2(cyc) bits.
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/memory_bus_master_if.sv
// Request/response handshake and memory control bundle for memory_bus_master.
// master modport: request in, response/err out, memory address and strobes out.
// slave modport: the requester/memory side view. The shared data bus is a separate inout net.
interface memory_bus_master_if
    import memory_bus_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              err;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, err, mem_addr, mem_read, mem_write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, err, mem_addr, mem_read, mem_write
    );
endinterface

// File: rtl/memory_bus_tristate.sv
// Bidirectional data-bus driver: drives i_dat onto io_bus while i_oe, otherwise releases it.
// Ports: i_oe drive enable, i_dat outgoing data, o_dat bus value as seen on the pin, io_bus shared net.
// Purely combinational, no latency, no backpressure.
module memory_bus_tristate #(
    parameter int DWIDTH = 8
) (
    input  logic              i_oe,
    input  logic [DWIDTH-1:0] i_dat,
    output logic [DWIDTH-1:0] o_dat,
    inout  wire  [DWIDTH-1:0] io_bus
);
    assign io_bus = i_oe ? i_dat : {DWIDTH{1'bz}};
    assign o_dat  = io_bus;
endmodule

// File: rtl/memory_bus_master.sv
// Sequences single-word reads/writes to the strobe-driven scratch memory (setup/strobe/hold).
// Latency: STROBE_CYC+3 cycles from acceptance to rsp_valid (write with verify: 2*(STROBE_CYC+3)-1).
// Backpressure: req_ready is high only in IDLE; one request in flight at a time.
// Ports: clk/rst (sync, active high); bus = request/response + mem_addr/mem_read/mem_write;
// mem_data = shared tristate data bus. Optional macro MEMORY_BUS_MASTER_VERIFY_EN adds a
// read-back after every write and a sticky err flag; without it err is tied 0.
module memory_bus_master
    import memory_bus_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int STROBE_CYC = DEF_STROBE_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    memory_bus_master_if.master        bus,
    inout  wire  [DWIDTH-1:0]          mem_data
);
    localparam int CW = cnt_width(STROBE_CYC);

    bus_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_write;
    logic [DWIDTH-1:0] r_wdata;
    logic [AWIDTH-1:0] r_addr;
    logic              r_ready;
    logic              r_rsp_vld;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rd;
    logic              r_wr;
    logic              r_bus_oe;
    logic [DWIDTH-1:0] w_bus_in;
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
    logic              r_err;
`endif

    memory_bus_tristate #(.DWIDTH(DWIDTH)) u_tri (
        .i_oe   (r_bus_oe),
        .i_dat  (r_wdata),
        .o_dat  (w_bus_in),
        .io_bus (mem_data)
    );

    // Every control output comes straight from a flop so the asynchronous memory
    // never sees combinational glitches on its strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_addr    <= '0;
            r_ready   <= 1'b1;
            r_rsp_vld <= 1'b0;
            r_rdata   <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_bus_oe  <= 1'b0;
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_ready  <= 1'b0;
                        // Writes put data on the bus a full cycle before the strobe.
                        r_bus_oe <= bus.req_write;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_cnt   <= CW'(STROBE_CYC - 1);
                    r_wr    <= r_write;
                    r_rd    <= !r_write;
                    r_state <= STROBE;
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_state <= HOLD;
                        if (!r_write) begin
                            r_rdata <= w_bus_in;
                        end
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
                        // A verified write reports completion only after its read-back.
                        r_rsp_vld <= !r_write;
`else
                        r_rsp_vld <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    r_bus_oe <= 1'b0;
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
                    if (r_write) begin
                        r_state <= VSETUP;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
`else
                    r_ready <= 1'b1;
                    r_state <= IDLE;
`endif
                end
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
                VSETUP: begin
                    r_cnt   <= CW'(STROBE_CYC - 1);
                    r_rd    <= 1'b1;
                    r_state <= VSTROBE;
                end
                VSTROBE: begin
                    if (r_cnt == '0) begin
                        r_rd      <= 1'b0;
                        r_rsp_vld <= 1'b1;
                        if (w_bus_in != r_wdata) begin
                            r_err <= 1'b1;
                        end
                        r_state   <= VHOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                VHOLD: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
`endif
                default: begin
                    r_rd     <= 1'b0;
                    r_wr     <= 1'b0;
                    r_bus_oe <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_rdata = r_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_read  = r_rd;
    assign bus.mem_write = r_wr;
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bus_master.sv
// Bench for memory_bus_master: scratch-memory model on the shared bus, directed scenarios,
// then randomized traffic. A transaction-level model predicts every output each cycle
// from the cycle offset within the current request.
`timescale 1ns/1ps
module tb_memory_bus_master;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int SC = 2;
`ifdef MEMORY_BUS_MASTER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [DW-1:0] mem_data;

    memory_bus_master_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();

    memory_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .STROBE_CYC(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Scratch memory: drives the bus while read strobe is high, latches while write strobe is high.
    logic [DW-1:0] mem_arr [2**AW];
    logic [DW-1:0] stuck_mask = '0;
    assign mem_data = bus.mem_read ? mem_arr[bus.mem_addr] : {DW{1'bz}};
    always @(posedge clk) if (bus.mem_write) mem_arr[bus.mem_addr] <= mem_data & ~stuck_mask;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    bit            m_live = 0;
    bit            m_act  = 0;
    int            m_start;
    logic          t_w;
    logic [AW-1:0] t_a;
    logic [DW-1:0] t_d;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err   = 1'b0;
    logic [DW-1:0] m_mem [2**AW];
    int n_wr_hi = 0, n_rd_hi = 0, n_rsp = 0, n_ovl = 0;

    always @(negedge clk) begin : mon
        int k, lt;
        bit strb, wr_e, rd_e, oe_e, rsp_e, rdy_e;
        n_wr_hi += int'(bus.mem_write);
        n_rd_hi += int'(bus.mem_read);
        n_rsp   += int'(bus.rsp_valid);
        n_ovl   += int'(bus.mem_read && bus.mem_write);
        if (m_live) begin
            k     = cyc - m_start;
            lt    = (m_act && t_w && VER) ? 2*SC + 5 : SC + 3;
            strb  = m_act && k >= 2 && k <= SC + 1;
            rdy_e = !m_act;
            wr_e  = strb && t_w;
            rd_e  = (strb && !t_w) || (m_act && t_w && VER && k >= SC + 4 && k <= 2*SC + 3);
            oe_e  = m_act && t_w && k >= 1 && k <= SC + 2;
            rsp_e = m_act && k == lt - 1;
            if (m_act && k >= 1) m_addr = t_a;
            if (wr_e && k == 2) m_mem[t_a] = t_d & ~stuck_mask;
            if (rsp_e && !t_w) m_rdata = m_mem[t_a];
            if (rsp_e && t_w && VER && ((t_d & ~stuck_mask) != t_d)) m_err = 1'b1;
            chk("req_ready", bus.req_ready, rdy_e);
            chk("mem_write", bus.mem_write, wr_e);
            chk("mem_read",  bus.mem_read,  rd_e);
            chk("bus_oe",    dut.r_bus_oe,  oe_e);
            chk("rsp_valid", bus.rsp_valid, rsp_e);
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("err",       bus.err,       m_err);
            if (oe_e) chk("bus_dat", mem_data, t_d);
            if (rsp_e) m_act = 0;
            if (!rst && bus.req_valid && rdy_e) begin
                m_act = 1; m_start = cyc;
                t_w = bus.req_write; t_a = bus.req_addr; t_d = bus.req_wdata;
            end
        end
        if (rst) begin
            m_live = 1; m_act = 0; m_addr = '0; m_rdata = '0; m_err = 1'b0;
        end
    end

    // All driving happens 1ns after a rising edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req_ready && !rst;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_act; i++) begin
            @(posedge clk); #1;
        end
        if (m_act) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic clr_cnt();
        n_wr_hi = 0; n_rd_hi = 0; n_rsp = 0; n_ovl = 0;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 2**AW; i++) begin mem_arr[i] = '0; m_mem[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", bus.req_ready, 1); chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0); chk("rst_err", bus.err, 0);
        chk("rst_addr", bus.mem_addr, 0);   chk("rst_rd", bus.mem_read, 0);
        chk("rst_wr", bus.mem_write, 0);    chk("rst_oe", dut.r_bus_oe, 0);

        // Write then read back address 5
        clr_cnt(); send(1'b1, 5'd5, 8'hA5); wait_idle();
        chk("wr5_strobe_cycles", n_wr_hi, SC); chk("wr5_rsp_count", n_rsp, 1);
        clr_cnt(); send(1'b0, 5'd5, 8'h00); wait_idle();
        chk("rd5_strobe_cycles", n_rd_hi, SC); chk("rd5_rsp_count", n_rsp, 1);
        chk("rd5_data", bus.rsp_rdata, 8'hA5);

        // Back-to-back with valid held high
        clr_cnt(); send(1'b1, 5'd31, 8'h3C); send(1'b0, 5'd31, 8'h00); wait_idle();
        chk("b2b_data", bus.rsp_rdata, 8'h3C); chk("b2b_rsp_count", n_rsp, 2);
        chk("b2b_overlap", n_ovl, 0);

        // Address boundaries
        send(1'b1, 5'd0, 8'hFF); send(1'b1, 5'd31, 8'h00);
        send(1'b0, 5'd0, 8'h00); wait_idle(); chk("addr0_data", bus.rsp_rdata, 8'hFF);
        send(1'b0, 5'd31, 8'h00); wait_idle(); chk("addr31_data", bus.rsp_rdata, 8'h00);

        // Reset during the strobe of a write
        clr_cnt(); send(1'b1, 5'd2, 8'h5A);
        @(posedge clk); #1;
        chk("mid_strobe_wr", bus.mem_write, 1);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("abort_wr", bus.mem_write, 0); chk("abort_rd", bus.mem_read, 0);
        chk("abort_oe", dut.r_bus_oe, 0); chk("abort_ready", bus.req_ready, 1);
        repeat (8) @(posedge clk); #1;
        chk("abort_no_rsp", n_rsp, 0);

`ifdef MEMORY_BUS_MASTER_VERIFY_EN
        stuck_mask = 8'h01;
        send(1'b1, 5'd7, 8'h01); wait_idle(); chk("verify_err_set", bus.err, 1);
        send(1'b1, 5'd7, 8'h02); wait_idle(); chk("verify_err_sticky", bus.err, 1);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("verify_err_rst", bus.err, 0);
        stuck_mask = 8'h00;
`endif

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 2**AW - 1));
            d = DW'($urandom);
            send(w, a, d);
        end
        wait_idle();
        chk("rand_overlap", n_ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
